// File: rtl/regfile_sb_if.sv
// Register file + scoreboard bus: read ports, write-back, reservations, status.
// Latency: carries no state; the timing of each signal is set by regfile_sb.
// Backpressure: none; every request is accepted in the cycle it is presented.
interface regfile_sb_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
);
    logic [NUM_RD*ADDR_W-1:0] RA;
    logic [NUM_RD*DATA_W-1:0] BusR;
    logic [NUM_RD-1:0]        Busy;
    logic [ADDR_W-1:0]        RW;
    logic [DATA_W-1:0]        BusW;
    logic                     RegWr;
    logic                     Resv;
    logic [ADDR_W-1:0]        ResvAddr;
    logic [ADDR_W:0]          BusyCnt;
    logic                     Err;

    // Requester side: drives addresses, write-back and reservations.
    modport master (
        output RA, RW, BusW, RegWr, Resv, ResvAddr,
        input  BusR, Busy, BusyCnt, Err
    );

    // Register file side.
    modport slave (
        input  RA, RW, BusW, RegWr, Resv, ResvAddr,
        output BusR, Busy, BusyCnt, Err
    );
endinterface

// File: rtl/regfile_sb.sv
// Multi-read-port register file with per-register busy scoreboard and sticky error.
// Latency: reads combinational; writes/reservations visible 1 cycle later, 0 when bypassed.
// Backpressure: none; writes and reservations are accepted every cycle.
module regfile_sb #(
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 31,
    parameter int ZERO_EN  = 1,
    parameter int BYPASS   = 1
) (
    input  logic         Clk,
    input  logic         Rst_n,
    regfile_sb_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZR = ADDR_W'(ZERO_REG);

    logic [DATA_W-1:0]        regs [DEPTH];
    logic [DEPTH-1:0]         busy;
    logic [DEPTH-1:0]         busy_nxt;
    logic [ADDR_W:0]          cnt_nxt;
    logic [ADDR_W:0]          busy_cnt;
    logic                     err;
    logic                     err_set;
    logic                     wr_en;
    logic [NUM_RD*DATA_W-1:0] busr;
    logic [NUM_RD-1:0]        busy_rd;

    // The hard-wired zero register silently swallows writes.
    assign wr_en = bus.RegWr && !((ZERO_EN != 0) && (bus.RW == ZR));

    // Next scoreboard: write-back clears, then a reservation sets (new reservation wins).
    always_comb begin
        busy_nxt = busy;
        if (bus.RegWr)
            busy_nxt[bus.RW] = 1'b0;
        if (bus.Resv)
            busy_nxt[bus.ResvAddr] = 1'b1;
        if (ZERO_EN != 0)
            busy_nxt[ZR] = 1'b0;
    end

    // Population count of the next scoreboard so the count lands on the same edge.
    always_comb begin
        cnt_nxt = '0;
        for (int k = 0; k < DEPTH; k++)
            cnt_nxt = cnt_nxt + (ADDR_W+1)'(busy_nxt[k]);
    end

    // Re-reserving a busy register is an error unless the same cycle writes it back.
    assign err_set = bus.Resv && busy[bus.ResvAddr] &&
                     !(bus.RegWr && (bus.RW == bus.ResvAddr));

    // Register array storage.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int k = 0; k < DEPTH; k++)
                regs[k] <= '0;
        end else if (wr_en) begin
            regs[bus.RW] <= bus.BusW;
        end
    end

    // Scoreboard, its count, and the sticky error flag.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            busy     <= '0;
            busy_cnt <= '0;
            err      <= 1'b0;
        end else begin
            busy     <= busy_nxt;
            busy_cnt <= cnt_nxt;
            if (err_set)
                err <= 1'b1;
        end
    end

    // Per-port read data and busy flag, with same-cycle write-back forwarding.
    always_comb begin
        busr    = '0;
        busy_rd = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            logic [ADDR_W-1:0] ra;
            logic              is_zero;
            logic              fwd;
            ra      = bus.RA[i*ADDR_W +: ADDR_W];
            is_zero = (ZERO_EN != 0) && (ra == ZR);
            fwd     = (BYPASS != 0) && bus.RegWr && (bus.RW == ra);
            if (is_zero) begin
                busr[i*DATA_W +: DATA_W] = '0;
                busy_rd[i]               = 1'b0;
            end else begin
                busr[i*DATA_W +: DATA_W] = fwd ? bus.BusW : regs[ra];
                busy_rd[i] = (fwd && !(bus.Resv && (bus.ResvAddr == ra))) ? 1'b0 : busy[ra];
            end
        end
    end

    assign bus.BusR    = busr;
    assign bus.Busy    = busy_rd;
    assign bus.BusyCnt = busy_cnt;
    assign bus.Err     = err;
endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;
    logic Clk = 1'b0;
    logic Rst_n = 1'b0;
    int n_checks = 0;
    int n_fail = 0;

    always #5 Clk = ~Clk;

    // bus0 drives the forwarding instance; bus1 mirrors its inputs into a non-forwarding one.
    regfile_sb_if #(.DATA_W(64), .ADDR_W(5), .NUM_RD(2)) bus0 ();
    regfile_sb_if #(.DATA_W(64), .ADDR_W(5), .NUM_RD(2)) bus1 ();

    assign bus1.RA       = bus0.RA;
    assign bus1.RW       = bus0.RW;
    assign bus1.BusW     = bus0.BusW;
    assign bus1.RegWr    = bus0.RegWr;
    assign bus1.Resv     = bus0.Resv;
    assign bus1.ResvAddr = bus0.ResvAddr;

    regfile_sb #(.DATA_W(64), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(31), .ZERO_EN(1), .BYPASS(1))
        dut_byp (.Clk(Clk), .Rst_n(Rst_n), .bus(bus0.slave));
    regfile_sb #(.DATA_W(64), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(31), .ZERO_EN(1), .BYPASS(0))
        dut_nobyp (.Clk(Clk), .Rst_n(Rst_n), .bus(bus1.slave));

    // Reference model: architectural state only.
    logic [63:0] m_reg [32];
    bit          m_busy [32];
    bit          m_err;

    function automatic void m_reset();
        for (int k = 0; k < 32; k++) begin
            m_reg[k]  = '0;
            m_busy[k] = 1'b0;
        end
        m_err = 1'b0;
    endfunction

    function automatic void m_edge();
        if (bus0.Resv && m_busy[bus0.ResvAddr] && !(bus0.RegWr && bus0.RW == bus0.ResvAddr))
            m_err = 1'b1;
        if (bus0.RegWr && bus0.RW != 5'd31)
            m_reg[bus0.RW] = bus0.BusW;
        if (bus0.RegWr)
            m_busy[bus0.RW] = 1'b0;
        if (bus0.Resv && bus0.ResvAddr != 5'd31)
            m_busy[bus0.ResvAddr] = 1'b1;
    endfunction

    function automatic logic [63:0] exp_busr(input logic [4:0] a, input bit byp);
        if (a == 5'd31) return 64'd0;
        if (byp && bus0.RegWr && bus0.RW == a) return bus0.BusW;
        return m_reg[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a, input bit byp);
        if (a == 5'd31) return 1'b0;
        if (byp && bus0.RegWr && bus0.RW == a && !(bus0.Resv && bus0.ResvAddr == a)) return 1'b0;
        return m_busy[a];
    endfunction

    function automatic logic [5:0] exp_cnt();
        int c = 0;
        for (int k = 0; k < 32; k++) c += int'(m_busy[k]);
        return 6'(c);
    endfunction

    task automatic idle();
        bus0.RA       = '0;
        bus0.RW       = '0;
        bus0.BusW     = '0;
        bus0.RegWr    = 1'b0;
        bus0.Resv     = 1'b0;
        bus0.ResvAddr = '0;
    endtask

    // One clock edge; the model follows only when reset is released.
    task automatic step();
        @(posedge Clk);
        if (Rst_n) m_edge();
        #1;
    endtask

    task automatic test_reset();
        idle();
        Rst_n = 1'b0;
        m_reset();
        // Operations presented during reset must be ignored.
        bus0.RegWr = 1'b1; bus0.RW = 5'd3; bus0.BusW = 64'hFF; bus0.Resv = 1'b1; bus0.ResvAddr = 5'd4;
        step();
        idle();
        for (int a = 0; a < 32; a++) begin
            logic [4:0] a0, a1;
            a0 = 5'(a);
            a1 = 5'(a + 1);
            bus0.RA = {a1, a0};
            #1;
            n_checks++;
            if (bus0.BusR !== 128'd0 || bus1.BusR !== 128'd0) begin
                n_fail++;
                $display("FAIL reset_busr addr=%0d got %h / %h expected 0", a, bus0.BusR, bus1.BusR);
            end
            n_checks++;
            if (bus0.Busy !== 2'b00 || bus1.Busy !== 2'b00) begin
                n_fail++;
                $display("FAIL reset_busy addr=%0d got %b / %b expected 00", a, bus0.Busy, bus1.Busy);
            end
        end
        n_checks++;
        if (bus0.BusyCnt !== 6'd0 || bus0.Err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_status got cnt=%0d err=%b expected cnt=0 err=0", bus0.BusyCnt, bus0.Err);
        end
        #2 Rst_n = 1'b1;
        // First edge after release accepts a write normally.
        bus0.RegWr = 1'b1; bus0.RW = 5'd6; bus0.BusW = 64'h0123_4567_89AB_CDEF;
        step();
        idle();
        bus0.RA = {5'd3, 5'd6};
        #1;
        n_checks++;
        if (bus1.BusR[63:0] !== 64'h0123_4567_89AB_CDEF) begin
            n_fail++;
            $display("FAIL first_write got %h expected 0123456789abcdef", bus1.BusR[63:0]);
        end
        n_checks++;
        if (bus1.BusR[127:64] !== 64'd0 || bus0.BusyCnt !== 6'd0) begin
            n_fail++;
            $display("FAIL reset_ignored got r3=%h cnt=%0d expected 0 0", bus1.BusR[127:64], bus0.BusyCnt);
        end
    endtask

    task automatic test_bypass();
        idle();
        bus0.RegWr = 1'b1; bus0.RW = 5'd3; bus0.BusW = 64'hDEAD_BEEF; bus0.RA = {5'd0, 5'd3};
        #1;
        n_checks++;
        if (bus0.BusR[63:0] !== 64'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL bypass_same_cycle got %h expected deadbeef", bus0.BusR[63:0]);
        end
        n_checks++;
        if (bus1.BusR[63:0] !== 64'd0) begin
            n_fail++;
            $display("FAIL nobypass_old_value got %h expected 0", bus1.BusR[63:0]);
        end
        step();
        bus0.RegWr = 1'b0;
        #1;
        n_checks++;
        if (bus0.BusR[63:0] !== 64'hDEAD_BEEF || bus1.BusR[63:0] !== 64'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL bypass_next_cycle got %h / %h expected deadbeef", bus0.BusR[63:0], bus1.BusR[63:0]);
        end
    endtask

    task automatic test_zero_reg();
        idle();
        bus0.RegWr = 1'b1; bus0.RW = 5'd31; bus0.BusW = 64'h1234;
        bus0.Resv = 1'b1; bus0.ResvAddr = 5'd31; bus0.RA = {5'd31, 5'd31};
        #1;
        n_checks++;
        if (bus0.BusR !== 128'd0 || bus0.Busy !== 2'b00) begin
            n_fail++;
            $display("FAIL zero_same_cycle got %h busy=%b expected 0 00", bus0.BusR, bus0.Busy);
        end
        step();
        bus0.RegWr = 1'b0; bus0.Resv = 1'b0;
        #1;
        n_checks++;
        if (bus0.BusR[63:0] !== 64'd0 || bus0.Busy[0] !== 1'b0 || bus0.BusyCnt !== 6'd0) begin
            n_fail++;
            $display("FAIL zero_after got %h busy=%b cnt=%0d expected 0 0 0",
                     bus0.BusR[63:0], bus0.Busy[0], bus0.BusyCnt);
        end
    endtask

    task automatic test_scoreboard();
        idle();
        bus0.Resv = 1'b1; bus0.ResvAddr = 5'd5;
        step();
        bus0.ResvAddr = 5'd7;
        step();
        idle();
        bus0.RA = {5'd7, 5'd5};
        #1;
        n_checks++;
        if (bus0.BusyCnt !== 6'd2 || bus0.Busy !== 2'b11) begin
            n_fail++;
            $display("FAIL resv_two got cnt=%0d busy=%b expected 2 11", bus0.BusyCnt, bus0.Busy);
        end
        // Write-back and fresh reservation to the same register in one cycle.
        bus0.RegWr = 1'b1; bus0.RW = 5'd5; bus0.BusW = 64'hA5A5;
        bus0.Resv = 1'b1; bus0.ResvAddr = 5'd5;
        #1;
        n_checks++;
        if (bus0.Busy[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL wr_resv_same_busy got %b expected 1", bus0.Busy[0]);
        end
        step();
        idle();
        bus0.RA = {5'd7, 5'd5};
        #1;
        n_checks++;
        if (bus0.Busy[0] !== 1'b1 || bus0.BusyCnt !== 6'd2 || bus0.Err !== 1'b0 ||
            bus0.BusR[63:0] !== 64'hA5A5) begin
            n_fail++;
            $display("FAIL wr_resv_after got busy=%b cnt=%0d err=%b data=%h expected 1 2 0 a5a5",
                     bus0.Busy[0], bus0.BusyCnt, bus0.Err, bus0.BusR[63:0]);
        end
    endtask

    function automatic logic [4:0] rnd_addr();
        int s = $urandom_range(0, 9);
        if (s == 0) return 5'd31;
        if (s < 7)  return 5'($urandom_range(0, 7));
        return 5'($urandom_range(0, 31));
    endfunction

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            bus0.RA       = {rnd_addr(), rnd_addr()};
            bus0.RW       = rnd_addr();
            bus0.BusW     = {$urandom, $urandom};
            bus0.RegWr    = ($urandom_range(0, 1) == 1);
            bus0.Resv     = ($urandom_range(0, 2) == 0);
            bus0.ResvAddr = ($urandom_range(0, 3) == 0) ? bus0.RW : rnd_addr();
            #1;
            for (int p = 0; p < 2; p++) begin
                logic [4:0] a;
                a = bus0.RA[p*5 +: 5];
                n_checks++;
                if (bus0.BusR[p*64 +: 64] !== exp_busr(a, 1'b1) ||
                    bus1.BusR[p*64 +: 64] !== exp_busr(a, 1'b0)) begin
                    n_fail++;
                    $display("FAIL rand_busr cyc=%0d port=%0d got %h / %h expected %h / %h", c, p,
                             bus0.BusR[p*64 +: 64], bus1.BusR[p*64 +: 64],
                             exp_busr(a, 1'b1), exp_busr(a, 1'b0));
                end
                n_checks++;
                if (bus0.Busy[p] !== exp_busy(a, 1'b1) || bus1.Busy[p] !== exp_busy(a, 1'b0)) begin
                    n_fail++;
                    $display("FAIL rand_busy cyc=%0d port=%0d got %b / %b expected %b / %b", c, p,
                             bus0.Busy[p], bus1.Busy[p], exp_busy(a, 1'b1), exp_busy(a, 1'b0));
                end
            end
            n_checks++;
            if (bus0.BusyCnt !== exp_cnt() || bus1.BusyCnt !== exp_cnt() ||
                bus0.Err !== m_err || bus1.Err !== m_err) begin
                n_fail++;
                $display("FAIL rand_status cyc=%0d got cnt=%0d/%0d err=%b/%b expected cnt=%0d err=%b", c,
                         bus0.BusyCnt, bus1.BusyCnt, bus0.Err, bus1.Err, exp_cnt(), m_err);
            end
            step();
        end
        idle();
    endtask

    task automatic test_double_resv();
        // Start from a clean scoreboard so the error is caused here.
        Rst_n = 1'b0;
        m_reset();
        #2 Rst_n = 1'b1;
        idle();
        bus0.Resv = 1'b1; bus0.ResvAddr = 5'd9;
        step();
        n_checks++;
        if (bus0.Err !== 1'b0) begin
            n_fail++;
            $display("FAIL single_resv_err got %b expected 0", bus0.Err);
        end
        step();
        idle();
        #1;
        n_checks++;
        if (bus0.Err !== 1'b1 || bus1.Err !== 1'b1) begin
            n_fail++;
            $display("FAIL double_resv_err got %b / %b expected 1", bus0.Err, bus1.Err);
        end
        bus0.RegWr = 1'b1; bus0.RW = 5'd9; bus0.BusW = 64'h77;
        step();
        bus0.RW = 5'd10;
        step();
        idle();
        #1;
        n_checks++;
        if (bus0.Err !== 1'b1 || bus0.BusyCnt !== 6'd0) begin
            n_fail++;
            $display("FAIL err_sticky got err=%b cnt=%0d expected 1 0", bus0.Err, bus0.BusyCnt);
        end
    endtask

    task automatic test_mid_reset();
        idle();
        bus0.RegWr = 1'b1; bus0.RW = 5'd2; bus0.BusW = 64'h55;
        step();
        idle();
        for (int r = 10; r < 14; r++) begin
            bus0.Resv = 1'b1; bus0.ResvAddr = 5'(r);
            step();
        end
        idle();
        bus0.RA = {5'd10, 5'd2};
        #1;
        n_checks++;
        if (bus0.BusyCnt !== 6'd4 || bus0.BusR[63:0] !== 64'h55 || bus0.Busy[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset got cnt=%0d r2=%h busy10=%b expected 4 55 1",
                     bus0.BusyCnt, bus0.BusR[63:0], bus0.Busy[1]);
        end
        Rst_n = 1'b0;
        m_reset();
        #1;
        n_checks++;
        if (bus0.BusyCnt !== 6'd0 || bus0.Err !== 1'b0 || bus0.BusR !== 128'd0 ||
            bus0.Busy !== 2'b00 || bus1.BusR !== 128'd0) begin
            n_fail++;
            $display("FAIL mid_reset got cnt=%0d err=%b busr=%h busy=%b expected 0 0 0 00",
                     bus0.BusyCnt, bus0.Err, bus0.BusR, bus0.Busy);
        end
        #1 Rst_n = 1'b1;
        step();
        #1;
        n_checks++;
        if (bus0.BusR[63:0] !== 64'd0 || bus0.BusyCnt !== 6'd0) begin
            n_fail++;
            $display("FAIL post_reset got r2=%h cnt=%0d expected 0 0", bus0.BusR[63:0], bus0.BusyCnt);
        end
    endtask

    initial begin
        idle();
        m_reset();
        #3;
        test_reset();
        test_bypass();
        test_zero_reg();
        test_scoreboard();
        test_random();
        test_double_resv();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter DATA_W, default 64, SHALL set the register data width in bits.
REQ-002 Parameter ADDR_W, default 5, SHALL set the address width; depth is 2**ADDR_W registers.
REQ-003 Parameter NUM_RD, default 2, SHALL set the number of independent read ports (1..4).
REQ-004 Parameter ZERO_REG, default 31, SHALL set the hard-wired-zero register index; ZERO_EN, default 1, SHALL enable it (0 = all registers writable).
REQ-005 Parameter BYPASS, default 1, SHALL enable write-to-read forwarding within the same cycle.
REQ-006 Clk  in  1  rising-edge clock for all state.
REQ-007 Rst_n  in  1  reset, asynchronous assert, active-low; one clock, reset is asynchronous and active-low.
REQ-008 RA  in  NUM_RD*ADDR_W  read addresses; port i uses bits [i*ADDR_W +: ADDR_W].
REQ-009 BusR  out  NUM_RD*DATA_W  read data; port i uses bits [i*DATA_W +: DATA_W].
REQ-010 Busy  out  NUM_RD  per-port flag: the addressed register has an outstanding reservation.
REQ-011 RW, BusW, RegWr  in  ADDR_W, DATA_W, 1  write-back address, data, enable.
REQ-012 Resv, ResvAddr  in  1, ADDR_W  reserve (mark pending-write) request and target address.
REQ-013 BusyCnt  out  ADDR_W+1  number of registers currently reserved.
REQ-014 Err  out  1  sticky double-reservation error flag.

Function
REQ-015 Write: on rising Clk with RegWr=1 and not (ZERO_EN and RW=ZERO_REG), registers[RW] SHALL take BusW; otherwise no register changes.
REQ-016 Read is combinational: BusR[i] SHALL be 0 when ZERO_EN and RA[i]=ZERO_REG, else registers[RA[i]].
REQ-017 When BYPASS=1, RegWr=1, RW=RA[i] and RA[i] is not the zero register, BusR[i] SHALL equal BusW in that same cycle; when BYPASS=0, BusR[i] SHALL show the old value until after the edge.
REQ-018 Scoreboard: one busy bit per register; on rising Clk, Resv=1 SHALL set busy[ResvAddr], and RegWr=1 SHALL clear busy[RW].
REQ-019 Resv and RegWr in the same cycle to the same address: busy SHALL end set (new reservation wins); data SHALL still be written.
REQ-020 Resv or RegWr targeting the zero register (ZERO_EN=1) SHALL leave its busy bit 0 permanently.
REQ-021 RegWr to a non-busy register SHALL write data and leave busy at 0 without error.
REQ-022 Busy[i] SHALL equal busy[RA[i]], forced to 0 for the zero register, and forced to 0 when BYPASS=1 and a same-cycle RegWr targets RA[i] without a same-cycle Resv to that address.
REQ-023 BusyCnt SHALL equal the population count of busy bits, updated registered on the same edge as the busy bits; it SHALL never exceed 2**ADDR_W.
REQ-024 Err SHALL set on rising Clk when Resv=1, ResvAddr is already busy, and no same-cycle RegWr clears that address; Err SHALL hold until reset.
REQ-025 Latency: write and scoreboard updates are visible on reads one cycle after the edge (zero cycles when bypassed per REQ-017/022).

Reset
REQ-026 Rst_n=0 SHALL asynchronously clear all registers to 0, all busy bits to 0, BusyCnt to 0 and Err to 0, regardless of Clk.
REQ-027 While Rst_n=0, writes and reservations SHALL be ignored; on release, the first rising Clk with Rst_n=1 SHALL accept operations normally.
REQ-028 Reset asserted mid-operation SHALL discard all pending reservations; no partial write SHALL survive.

Verification
REQ-029 Reset, then read every address on all ports -> BusR all 0, Busy all 0, BusyCnt=0, Err=0.
REQ-030 RegWr RW=3 BusW=0xDEAD_BEEF with RA[0]=3 same cycle -> BusR[0]=0xDEAD_BEEF immediately (BYPASS=1); next cycle still 0xDEAD_BEEF; with BYPASS=0 the old value 0 appears until the edge.
REQ-031 RegWr RW=31 BusW=0x1234 and Resv ResvAddr=31 -> reading 31 gives 0, Busy=0, BusyCnt unchanged.
REQ-032 Resv 5, Resv 7 -> BusyCnt=2, Busy for RA=5 is 1; then RegWr 5 and Resv 5 in the same cycle -> busy[5] stays 1, BusyCnt=2, Err=0.
REQ-033 Resv 9 twice in consecutive cycles without write-back -> Err=1 after the second edge and remains 1 through subsequent writes.
REQ-034 Reserve 4 registers and write register 2 to 0x55, then pulse Rst_n low between edges -> all outputs cleared immediately, register 2 reads 0, BusyCnt=0.
